// File: rtl/uart_pkt_sender.sv
// Frames a latched payload as SOF, LEN, payload bytes, XOR checksum, EOF and pushes
// it one byte per accepted cycle into the UART TX FIFO, stalling on tx_full.
module uart_pkt_sender #(
    parameter int          PAYLOAD_BYTES = 4,
    parameter logic [7:0]  SOF_BYTE      = 8'h02,
    parameter logic [7:0]  EOF_BYTE      = 8'h03
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         send_req,
    input  logic [8*PAYLOAD_BYTES-1:0]   payload,
    input  logic                         tx_full,
    output logic                         tx_push,
    output logic [7:0]                   tx_push_data,
    output logic                         busy,
    output logic                         pkt_done,
    output logic                         req_drop
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_EOF
    } state_t;

    localparam logic [7:0] LEN_BYTE = 8'(PAYLOAD_BYTES);
    localparam logic [3:0] LAST_IDX = 4'(PAYLOAD_BYTES - 1);

    state_t                       state_q, state_d;
    logic [8*PAYLOAD_BYTES-1:0]   payload_q, payload_d;
    logic [3:0]                   idx_q, idx_d;
    logic [7:0]                   csum_q, csum_d;
    logic                         pkt_done_q, pkt_done_d;
    logic                         req_drop_q, req_drop_d;

    logic [7:0] in_bytes   [PAYLOAD_BYTES];
    logic [7:0] held_bytes [PAYLOAD_BYTES];
    logic [7:0] csum_in;
    logic [7:0] data_sel;
    logic       accept;

    generate
        for (genvar gi = 0; gi < PAYLOAD_BYTES; gi++) begin : g_bytes
            assign in_bytes[gi]   = payload[gi*8 +: 8];
            assign held_bytes[gi] = payload_q[gi*8 +: 8];
        end
    endgenerate

    // Checksum is folded at request time so CSUM needs no extra cycle.
    always_comb begin
        csum_in = LEN_BYTE;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            csum_in = csum_in ^ in_bytes[i];
        end
    end

    always_comb begin
        data_sel = 8'h00;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            if (idx_q == 4'(i)) begin
                data_sel = held_bytes[i];
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign tx_push  = busy && !tx_full;
    assign accept   = tx_push;
    assign pkt_done = pkt_done_q;
    assign req_drop = req_drop_q;

    always_comb begin
        state_d      = state_q;
        payload_d    = payload_q;
        idx_d        = idx_q;
        csum_d       = csum_q;
        pkt_done_d   = 1'b0;
        req_drop_d   = send_req && (state_q != ST_IDLE);
        tx_push_data = 8'h00;
        unique case (state_q)
            ST_IDLE: begin
                if (send_req) begin
                    payload_d = payload;
                    csum_d    = csum_in;
                    idx_d     = 4'd0;
                    state_d   = ST_SOF;
                end
            end
            ST_SOF: begin
                tx_push_data = SOF_BYTE;
                if (accept) state_d = ST_LEN;
            end
            ST_LEN: begin
                tx_push_data = LEN_BYTE;
                if (accept) state_d = ST_DATA;
            end
            ST_DATA: begin
                tx_push_data = data_sel;
                if (accept) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_CSUM;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_CSUM: begin
                tx_push_data = csum_q;
                if (accept) state_d = ST_EOF;
            end
            ST_EOF: begin
                tx_push_data = EOF_BYTE;
                if (accept) begin
                    state_d    = ST_IDLE;
                    pkt_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            payload_q  <= '0;
            idx_q      <= 4'd0;
            csum_q     <= 8'h00;
            pkt_done_q <= 1'b0;
            req_drop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            payload_q  <= payload_d;
            idx_q      <= idx_d;
            csum_q     <= csum_d;
            pkt_done_q <= pkt_done_d;
            req_drop_q <= req_drop_d;
        end
    end

endmodule

// File: tb/tb_uart_pkt_sender.sv
// Directed and randomised-backpressure checks of uart_pkt_sender framing, stalls,
// dropped requests, mid-frame reset and back-to-back frames.
module tb_uart_pkt_sender;

    logic        clk;
    logic        reset;
    logic        send_req;
    logic [31:0] payload;
    logic        tx_full;
    logic        tx_push;
    logic [7:0]  tx_push_data;
    logic        busy;
    logic        pkt_done;
    logic        req_drop;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_b [8];

    uart_pkt_sender #(
        .PAYLOAD_BYTES (4),
        .SOF_BYTE      (8'h02),
        .EOF_BYTE      (8'h03)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .send_req     (send_req),
        .payload      (payload),
        .tx_full      (tx_full),
        .tx_push      (tx_push),
        .tx_push_data (tx_push_data),
        .busy         (busy),
        .pkt_done     (pkt_done),
        .req_drop     (req_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench 1 time unit after a rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [31:0] p);
        send_req = 1'b1;
        payload  = p;
        tick();
        send_req = 1'b0;
        payload  = 32'hDEADBEEF;
    endtask

    task automatic test_reset();
        reset = 1'b1; send_req = 1'b0; payload = 32'h0; tx_full = 1'b0;
        #2;
        checks++;
        if (tx_push !== 1'b0 || tx_push_data !== 8'h00 || busy !== 1'b0 ||
            pkt_done !== 1'b0 || req_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: push=%b data=%h busy=%b done=%b drop=%b required 0 00 0 0 0",
                     tx_push, tx_push_data, busy, pkt_done, req_drop);
        end
        tick(); tick();
        reset = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_basic();
        exp_b = '{8'h02, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40, 8'h03};
        start_frame(32'h44332211);
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (tx_push !== 1'b1 || tx_push_data !== exp_b[k] || busy !== 1'b1) begin
                errors++;
                $display("FAIL basic_byte%0d: push=%b data=%h busy=%b required 1 %h 1",
                         k, tx_push, tx_push_data, busy, exp_b[k]);
            end
            tick();
        end
        #1;
        checks++;
        if (pkt_done !== 1'b1 || busy !== 1'b0 || tx_push !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b busy=%b push=%b required 1 0 0", pkt_done, busy, tx_push);
        end
        tick();
        checks++;
        if (pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b required 0", pkt_done);
        end
        $display("test_basic done");
    endtask

    task automatic test_stall();
        exp_b = '{8'h02, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40, 8'h03};
        start_frame(32'h44332211);
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                for (int s = 0; s < 5; s++) begin
                    tx_full = 1'b1;
                    #1;
                    checks++;
                    if (tx_push !== 1'b0 || tx_push_data !== 8'h22 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_hold%0d: push=%b data=%h busy=%b required 0 22 1",
                                 s, tx_push, tx_push_data, busy);
                    end
                    tick();
                end
                tx_full = 1'b0;
            end
            #1;
            checks++;
            if (tx_push !== 1'b1 || tx_push_data !== exp_b[k]) begin
                errors++;
                $display("FAIL stall_byte%0d: push=%b data=%h required 1 %h", k, tx_push, tx_push_data, exp_b[k]);
            end
            tick();
        end
        #1;
        checks++;
        if (pkt_done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: done=%b required 1", pkt_done);
        end
        tick();
        $display("test_stall done");
    endtask

    task automatic test_drop();
        exp_b = '{8'h02, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40, 8'h03};
        start_frame(32'h44332211);
        for (int k = 0; k < 8; k++) begin
            send_req = (k == 2);
            if (k == 2) payload = 32'hA5A5A5A5;
            #1;
            checks++;
            if (tx_push !== 1'b1 || tx_push_data !== exp_b[k] || busy !== 1'b1) begin
                errors++;
                $display("FAIL drop_byte%0d: push=%b data=%h busy=%b required 1 %h 1",
                         k, tx_push, tx_push_data, busy, exp_b[k]);
            end
            checks++;
            if (req_drop !== (k == 3)) begin
                errors++;
                $display("FAIL drop_flag%0d: req_drop=%b required %b", k, req_drop, (k == 3));
            end
            tick();
        end
        send_req = 1'b0;
        #1;
        checks++;
        if (pkt_done !== 1'b1 || req_drop !== 1'b0) begin
            errors++;
            $display("FAIL drop_done: done=%b drop=%b required 1 0", pkt_done, req_drop);
        end
        tick();
        $display("test_drop done");
    endtask

    task automatic test_reset_mid();
        exp_b = '{8'h02, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40, 8'h03};
        start_frame(32'h44332211);
        for (int k = 0; k < 4; k++) tick();
        #1;
        checks++;
        if (tx_push_data !== 8'h33) begin
            errors++;
            $display("FAIL rstmid_pre: data=%h required 33", tx_push_data);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (tx_push !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: push=%b busy=%b required 0 0", tx_push, busy);
        end
        tick();
        reset = 1'b0;
        tick();
        exp_b = '{8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h03};
        start_frame(32'h00000000);
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (tx_push !== 1'b1 || tx_push_data !== exp_b[k]) begin
                errors++;
                $display("FAIL rstmid_byte%0d: push=%b data=%h required 1 %h", k, tx_push, tx_push_data, exp_b[k]);
            end
            tick();
        end
        tick();
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        exp_b = '{8'h02, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40, 8'h03};
        start_frame(32'h44332211);
        for (int k = 0; k < 8; k++) tick();
        send_req = 1'b1;
        payload  = 32'hFFFFFFFF;
        #1;
        checks++;
        if (pkt_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: done=%b busy=%b required 1 0", pkt_done, busy);
        end
        tick();
        send_req = 1'b0;
        payload  = 32'h0;
        exp_b = '{8'h02, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h04, 8'h03};
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (tx_push !== 1'b1 || tx_push_data !== exp_b[k]) begin
                errors++;
                $display("FAIL b2b_byte%0d: push=%b data=%h required 1 %h", k, tx_push, tx_push_data, exp_b[k]);
            end
            tick();
        end
        tick();
        $display("test_back_to_back done");
    endtask

    task automatic test_random();
        logic [31:0] p;
        logic [7:0]  cs;
        int          got;
        int          budget;
        int          frame_errs;
        for (int f = 0; f < 100; f++) begin
            p  = $urandom;
            cs = 8'h04 ^ p[7:0] ^ p[15:8] ^ p[23:16] ^ p[31:24];
            exp_b = '{8'h02, 8'h04, p[7:0], p[15:8], p[23:16], p[31:24], cs, 8'h03};
            start_frame(p);
            got = 0;
            budget = 200;
            frame_errs = errors;
            while (got < 8 && budget > 0) begin
                tx_full = ($urandom_range(0, 2) == 0);
                #1;
                checks++;
                if (tx_push !== !tx_full) begin
                    errors++;
                    $display("FAIL rand_push f%0d: push=%b required %b (tx_full=%b)", f, tx_push, !tx_full, tx_full);
                end
                if (tx_push === 1'b1) begin
                    checks++;
                    if (tx_push_data !== exp_b[got]) begin
                        errors++;
                        $display("FAIL rand_byte f%0d b%0d: data=%h required %h", f, got, tx_push_data, exp_b[got]);
                    end
                    got++;
                end
                budget--;
                tick();
            end
            tx_full = 1'b0;
            if (got < 8) begin
                errors++;
                $display("FAIL rand_timeout f%0d: bytes=%0d required 8", f, got);
            end
            #1;
            checks++;
            if (pkt_done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_done f%0d: done=%b busy=%b required 1 0", f, pkt_done, busy);
            end
            $display("frame %0d payload=%h csum=%h errors_in_frame=%0d", f, p, cs, errors - frame_errs);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
